// File: rtl/audio_downsample_loopback.sv
// Downsampling stage between the codec ADC and DAC sides: consumes one stereo
// sample per handshake, decimates or block-averages it, and writes it back out.
module audio_downsample_loopback #(
    parameter int DATA_WIDTH  = 32,
    parameter int FACTOR_LOG2 = 2,
    parameter int MODE        = 0,
    parameter int OUT_TIMEOUT = 1024
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  bypass,
    input  logic                  audio_in_available,
    input  logic [DATA_WIDTH-1:0] left_channel_audio_in,
    input  logic [DATA_WIDTH-1:0] right_channel_audio_in,
    input  logic                  audio_out_allowed,
    output logic                  read_audio_in,
    output logic                  write_audio_out,
    output logic [DATA_WIDTH-1:0] left_channel_audio_out,
    output logic [DATA_WIDTH-1:0] right_channel_audio_out,
    output logic [15:0]           drop_count
);

    localparam int ACC_W = DATA_WIDTH + FACTOR_LOG2;
    localparam int PH_W  = (FACTOR_LOG2 > 0) ? FACTOR_LOG2 : 1;
    localparam int WC_W  = (OUT_TIMEOUT > 1) ? $clog2(OUT_TIMEOUT) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'((1 << FACTOR_LOG2) - 1);
    localparam logic [WC_W-1:0] WC_LAST = WC_W'(OUT_TIMEOUT - 1);

    typedef enum logic [1:0] {
        WAIT_IN  = 2'd0,
        CAPTURE  = 2'd1,
        WAIT_OUT = 2'd2,
        EMIT     = 2'd3
    } state_t;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_WIDTH-1:0] x);
        return ACC_W'(x);
    endfunction

    // Arithmetic shift floors toward -inf; the quotient always fits DATA_WIDTH.
    function automatic logic signed [DATA_WIDTH-1:0] avg_shift(input logic signed [ACC_W-1:0] s);
        logic signed [ACC_W-1:0] t;
        t = s >>> FACTOR_LOG2;
        return t[DATA_WIDTH-1:0];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    state_t                         state_q, state_d;
    logic                           tmo;
    logic                           cap_en;
    logic [WC_W-1:0]                wait_cnt_q;
    logic [15:0]                    drop_cnt_q, drop_cnt_d;
    logic                           rd_vld_p0;
    logic                           wr_vld_p1;
    logic [PH_W-1:0]                phase_q, phase_nxt;
    logic signed [DATA_WIDTH-1:0]   cap_l_p0, cap_r_p0;
    logic signed [ACC_W-1:0]        acc_l_p1, acc_r_p1;
    logic signed [ACC_W-1:0]        sum_l, sum_r;
    logic signed [DATA_WIDTH-1:0]   hold_l_p1, hold_r_p1;

    assign cap_en = (state_q == WAIT_IN) && audio_in_available;

    always_comb begin
        state_d    = state_q;
        tmo        = 1'b0;
        drop_cnt_d = drop_cnt_q;
        case (state_q)
            WAIT_IN:  if (audio_in_available) state_d = CAPTURE;
            CAPTURE:  state_d = WAIT_OUT;
            WAIT_OUT: begin
                if (audio_out_allowed) begin
                    state_d = EMIT;
                end else if (wait_cnt_q == WC_LAST) begin
                    state_d = WAIT_IN;
                    tmo     = 1'b1;
                end
            end
            EMIT:     state_d = WAIT_IN;
            default:  state_d = WAIT_IN;
        endcase
        if (tmo) drop_cnt_d = sat_inc(drop_cnt_q);
    end

    // Handshake pulses are registered from the next state so they line up with it.
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q    <= WAIT_IN;
            rd_vld_p0  <= 1'b0;
            wr_vld_p1  <= 1'b0;
            wait_cnt_q <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_vld_p0  <= (state_d == CAPTURE);
            wr_vld_p1  <= (state_d == EMIT);
            drop_cnt_q <= drop_cnt_d;
            if (state_q == CAPTURE) begin
                wait_cnt_q <= '0;
            end else if ((state_q == WAIT_OUT) && !audio_out_allowed && !tmo) begin
                wait_cnt_q <= wait_cnt_q + WC_W'(1);
            end
        end
    end

    always_comb begin
        sum_l     = sext(cap_l_p0);
        sum_r     = sext(cap_r_p0);
        phase_nxt = (phase_q == PH_LAST) ? '0 : phase_q + PH_W'(1);
        if (phase_q != '0) begin
            sum_l = acc_l_p1 + sext(cap_l_p0);
            sum_r = acc_r_p1 + sext(cap_r_p0);
        end
    end

    // p0: capture the input pair when it is accepted
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            cap_l_p0 <= '0;
            cap_r_p0 <= '0;
        end else if (cap_en) begin
            cap_l_p0 <= $signed(left_channel_audio_in);
            cap_r_p0 <= $signed(right_channel_audio_in);
        end
    end

    // p1: decimate / average during CAPTURE; hold registers feed the DAC side
    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            phase_q   <= '0;
            acc_l_p1  <= '0;
            acc_r_p1  <= '0;
            hold_l_p1 <= '0;
            hold_r_p1 <= '0;
        end else if (state_q == CAPTURE) begin
            if (bypass) begin
                phase_q   <= '0;
                acc_l_p1  <= '0;
                acc_r_p1  <= '0;
                hold_l_p1 <= cap_l_p0;
                hold_r_p1 <= cap_r_p0;
            end else begin
                phase_q <= phase_nxt;
                if (MODE == 0) begin
                    if (phase_q == '0) begin
                        hold_l_p1 <= cap_l_p0;
                        hold_r_p1 <= cap_r_p0;
                    end
                end else begin
                    acc_l_p1 <= sum_l;
                    acc_r_p1 <= sum_r;
                    if (phase_q == PH_LAST) begin
                        hold_l_p1 <= avg_shift(sum_l);
                        hold_r_p1 <= avg_shift(sum_r);
                    end
                end
            end
        end
    end

    assign read_audio_in           = rd_vld_p0;
    assign write_audio_out         = wr_vld_p1;
    assign left_channel_audio_out  = hold_l_p1;
    assign right_channel_audio_out = hold_r_p1;
    assign drop_count              = drop_cnt_q;

endmodule

// File: tb/tb_audio_downsample_loopback.sv
// Directed bench for audio_downsample_loopback: decimation, averaging, backpressure,
// timeout/saturation, bypass and reset, with queued expected output samples.
module tb_audio_downsample_loopback;

    localparam int W = 32;

    typedef struct {
        logic [W-1:0] l;
        logic [W-1:0] r;
    } pair_t;

    logic CLOCK_50 = 1'b0;
    always #10 CLOCK_50 = ~CLOCK_50;

    logic         reset, bypass, avail, allowed, avail_c, allowed_c;
    logic [W-1:0] left_in, right_in;
    logic         read_a, write_a, read_b, write_b, read_c, write_c;
    logic [W-1:0] lo_a, ro_a, lo_b, ro_b, lo_c, ro_c;
    logic [15:0]  drop_a, drop_b, drop_c;

    int total = 0;
    int bad   = 0;
    pair_t qa[$];
    pair_t qb[$];

    int bl2[8]  = '{0, 0, 0, 2, 2, 2, 2, 6};
    int br2[8]  = '{0, 0, 0, -3, -3, -3, -3, -7};
    int in3[12] = '{4, 8, -4, 0, 1, 1, 1, 2, -1, 0, 0, 0};
    int al3[12] = '{4, 4, 4, 4, 1, 1, 1, 1, -1, -1, -1, -1};
    int bl3[12] = '{0, 0, 0, 2, 2, 2, 2, 1, 1, 1, 1, -1};
    int br3[12] = '{0, 0, 0, -2, -2, -2, -2, -2, -2, -2, -2, 0};
    int bp6[8]  = '{0, 0, 1, 1, 0, 0, 0, 0};
    int al6[8]  = '{10, 10, 30, 40, 50, 50, 50, 50};
    int bl6[8]  = '{0, 0, 30, 40, 40, 40, 40, 65};
    int dp5[6]  = '{0, 1, 2, 'hFFFD, 'hFFFE, 'hFFFF};
    int dn5[6]  = '{1, 2, 3, 'hFFFE, 'hFFFF, 'hFFFF};
    int lc5[6]  = '{11, 11, 11, 11, 15, 15};

    audio_downsample_loopback #(.DATA_WIDTH(W), .FACTOR_LOG2(2), .MODE(0), .OUT_TIMEOUT(1024)) dut_a (
        .CLOCK_50(CLOCK_50), .reset(reset), .bypass(bypass),
        .audio_in_available(avail), .left_channel_audio_in(left_in), .right_channel_audio_in(right_in),
        .audio_out_allowed(allowed), .read_audio_in(read_a), .write_audio_out(write_a),
        .left_channel_audio_out(lo_a), .right_channel_audio_out(ro_a), .drop_count(drop_a)
    );

    audio_downsample_loopback #(.DATA_WIDTH(W), .FACTOR_LOG2(2), .MODE(1), .OUT_TIMEOUT(1024)) dut_b (
        .CLOCK_50(CLOCK_50), .reset(reset), .bypass(bypass),
        .audio_in_available(avail), .left_channel_audio_in(left_in), .right_channel_audio_in(right_in),
        .audio_out_allowed(allowed), .read_audio_in(read_b), .write_audio_out(write_b),
        .left_channel_audio_out(lo_b), .right_channel_audio_out(ro_b), .drop_count(drop_b)
    );

    audio_downsample_loopback #(.DATA_WIDTH(W), .FACTOR_LOG2(2), .MODE(0), .OUT_TIMEOUT(4)) dut_c (
        .CLOCK_50(CLOCK_50), .reset(reset), .bypass(bypass),
        .audio_in_available(avail_c), .left_channel_audio_in(left_in), .right_channel_audio_in(right_in),
        .audio_out_allowed(allowed_c), .read_audio_in(read_c), .write_audio_out(write_c),
        .left_channel_audio_out(lo_c), .right_channel_audio_out(ro_c), .drop_count(drop_c)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int al, input int ar, input int bl, input int br);
        pair_t p;
        p.l = al;
        p.r = ar;
        qa.push_back(p);
        p.l = bl;
        p.r = br;
        qb.push_back(p);
    endtask

    task automatic wait_read_a();
        int n;
        n = 0;
        do begin
            @(negedge CLOCK_50);
            n++;
        end while (read_a !== 1'b1 && n < 50);
        chk("read_seen", 32'(read_a), 1);
    endtask

    task automatic send(input int l, input int r);
        int n;
        left_in  = l;
        right_in = r;
        avail    = 1'b1;
        wait_read_a();
        avail = 1'b0;
        n = 0;
        while (write_a !== 1'b1 && n < 2000) begin
            @(negedge CLOCK_50);
            n++;
        end
        chk("write_seen", 32'(write_a), 1);
    endtask

    task automatic do_reset();
        avail = 1'b0;
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
    endtask

    always @(negedge CLOCK_50) begin : mon_a
        pair_t e;
        if (read_a === 1'b1) chk("a_rw_excl", 32'(write_a), 0);
        if (write_a === 1'b1) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_write", 32'(write_a), 0);
            end else begin
                e = qa.pop_front();
                chk("a_left", lo_a, e.l);
                chk("a_right", ro_a, e.r);
            end
        end
    end

    always @(negedge CLOCK_50) begin : mon_b
        pair_t e;
        if (write_b === 1'b1) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_write", 32'(write_b), 0);
            end else begin
                e = qb.pop_front();
                chk("b_left", lo_b, e.l);
                chk("b_right", ro_b, e.r);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset     = 1'b0;
        bypass    = 1'b0;
        avail     = 1'b1;
        allowed   = 1'b1;
        avail_c   = 1'b0;
        allowed_c = 1'b0;
        left_in   = 7;
        right_in  = -7;

        // reset values and first-transaction latency
        repeat (3) begin
            @(negedge CLOCK_50);
            chk("rst_read", 32'(read_a), 0);
            chk("rst_write", 32'(write_a), 0);
            chk("rst_left", lo_a, 0);
            chk("rst_right", ro_a, 0);
            chk("rst_drop", 32'(drop_a), 0);
            chk("rst_left_b", lo_b, 0);
            chk("rst_read_b", 32'(read_b), 0);
        end
        push(7, -7, 0, 0);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("lat_read_t1", 32'(read_a), 1);
        chk("lat_write_t1", 32'(write_a), 0);
        avail = 1'b0;
        @(negedge CLOCK_50);
        chk("lat_read_t2", 32'(read_a), 0);
        chk("lat_write_t2", 32'(write_a), 0);
        @(negedge CLOCK_50);
        chk("lat_write_t3", 32'(write_a), 1);

        // decimation / averaging of 1..8
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            push((i <= 4) ? 1 : 5, (i <= 4) ? -1 : -5, bl2[i-1], br2[i-1]);
            send(i, -i);
        end

        // block average with floor rounding
        do_reset();
        for (int i = 0; i < 12; i++) begin
            push(al3[i], -al3[i], bl3[i], br3[i]);
            send(in3[i], -in3[i]);
        end

        // backpressure: stall 10 cycles with available held high
        allowed  = 1'b0;
        left_in  = 100;
        right_in = -100;
        push(100, -100, -1, 0);
        avail = 1'b1;
        wait_read_a();
        for (int i = 0; i < 10; i++) begin
            @(negedge CLOCK_50);
            chk("bp_no_write", 32'(write_a), 0);
            chk("bp_no_read", 32'(read_a), 0);
        end
        avail   = 1'b0;
        allowed = 1'b1;
        @(negedge CLOCK_50);
        chk("bp_write_next", 32'(write_a), 1);

        // bypass toggled mid-block
        do_reset();
        for (int i = 0; i < 8; i++) begin
            bypass = bp6[i][0];
            push(al6[i], -al6[i], bl6[i], -bl6[i]);
            send(10 * (i + 1), -10 * (i + 1));
        end
        bypass = 1'b0;

        // reset while waiting for output
        allowed  = 1'b0;
        left_in  = 999;
        right_in = -999;
        avail    = 1'b1;
        wait_read_a();
        avail = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        reset   = 1'b1;
        allowed = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK_50);
            chk("mr_no_write", 32'(write_a), 0);
        end
        chk("mr_left", lo_a, 0);
        chk("mr_right", ro_a, 0);
        chk("mr_drop", 32'(drop_a), 0);

        // timeout drops and saturation on the OUT_TIMEOUT=4 instance
        for (int k = 0; k < 6; k++) begin
            if (k == 3) begin
                @(negedge CLOCK_50);
                force dut_c.drop_cnt_q = 16'hFFFD;
                repeat (2) @(negedge CLOCK_50);
                release dut_c.drop_cnt_q;
            end
            left_in  = 11 + k;
            right_in = -(11 + k);
            avail_c  = 1'b1;
            n = 0;
            do begin
                @(negedge CLOCK_50);
                n++;
            end while (read_c !== 1'b1 && n < 50);
            avail_c = 1'b0;
            chk("to_read", 32'(read_c), 1);
            repeat (3) begin
                @(negedge CLOCK_50);
                chk("to_no_write", 32'(write_c), 0);
            end
            @(negedge CLOCK_50);
            chk("to_drop_before", 32'(drop_c), dp5[k]);
            chk("to_no_write_last", 32'(write_c), 0);
            @(negedge CLOCK_50);
            chk("to_drop_after", 32'(drop_c), dn5[k]);
            chk("to_left_held", lo_c, lc5[k]);
            chk("to_right_held", ro_c, -lc5[k]);
        end

        @(negedge CLOCK_50);
        chk("qa_drained", qa.size(), 0);
        chk("qb_drained", qb.size(), 0);
        chk("end_drop_b", 32'(drop_b), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/audio_downsample_loopback.md
# audio_downsample_loopback

Parametrised downsampling stage between the audio codec controller's ADC and DAC sides. It replaces the free-running always-enabled loopback with a proper read/write handshake. Each stereo input sample is consumed with a single-cycle `read_audio_in` pulse and reduced by a factor of 2^FACTOR_LOG2, either by sample-and-hold decimation or by block averaging. One output sample is written per input sample, so the codec rate is unchanged. Output backpressure is handled with a bounded timeout.

## Interface
- `DATA_WIDTH`, 32: bits per channel sample, two's complement.
- `FACTOR_LOG2`, 2: downsampling factor is 2^FACTOR_LOG2. Legal range 0..8; 0 = pass-through rate.
- `MODE`, 0: 0 = sample-and-hold decimation, 1 = block average.
- `OUT_TIMEOUT`, 1024: maximum cycles spent waiting for `audio_out_allowed` before the sample is dropped. Must be ≥1.

- `CLOCK_50` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `bypass` in 1: 1 = every input sample is forwarded unmodified.
- `audio_in_available` in 1: controller has an input sample.
- `left_channel_audio_in` in DATA_WIDTH: left ADC sample.
- `right_channel_audio_in` in DATA_WIDTH: right ADC sample.
- `audio_out_allowed` in 1: controller can accept an output sample.
- `read_audio_in` out 1: one-cycle pulse that consumes an input sample.
- `write_audio_out` out 1: one-cycle pulse that writes an output sample.
- `left_channel_audio_out` out DATA_WIDTH: left DAC sample.
- `right_channel_audio_out` out DATA_WIDTH: right DAC sample.
- `drop_count` out 16: saturating count of output samples dropped on timeout.

## Operation
- **State machine:** WAIT_IN → CAPTURE → WAIT_OUT → EMIT → WAIT_IN.
  - WAIT_IN: if `audio_in_available`=1, register both input channels into capture registers and go to CAPTURE.
  - CAPTURE (1 cycle): `read_audio_in`=1. Apply the processing update below. Go to WAIT_OUT.
  - WAIT_OUT: if `audio_out_allowed`=1, go to EMIT. Otherwise increment the wait counter. When the wait counter reaches OUT_TIMEOUT−1 with `audio_out_allowed`=0, go to WAIT_IN, increment `drop_count` (saturates at 16'hFFFF), and leave the output registers unchanged.
  - EMIT (1 cycle): `write_audio_out`=1. Go to WAIT_IN. The wait counter clears on entry to WAIT_OUT.
- **Phase counter:** FACTOR_LOG2 bits, wraps modulo 2^FACTOR_LOG2. Advances once per CAPTURE. Not advanced on timeout-dropped writes, because the sample was already consumed in CAPTURE.
- **MODE 0:** at phase 0, the hold registers load the captured samples. At other phases the hold registers keep their value.
- **MODE 1:** per-channel accumulator, DATA_WIDTH+FACTOR_LOG2 bits, sign-extended adds.
  - Phase 0: acc = sample.
  - Other phases: acc = acc + sample.
  - At phase 2^FACTOR_LOG2−1: hold = (acc + sample) >>> FACTOR_LOG2, arithmetic shift truncating toward −∞. The accumulator then restarts at the next phase 0.
- **Bypass:** while `bypass`=1, hold = captured sample at every CAPTURE, and phase and accumulators are forced to 0. A 1→0 transition therefore starts a fresh block at phase 0.
- **Outputs:** `left_channel_audio_out` and `right_channel_audio_out` are driven from the hold registers and are stable between EMITs.
- **FACTOR_LOG2=0:** every sample is forwarded in both modes.
- **Reset:** when `reset`=0 at a rising edge, the block goes to WAIT_IN and all state is cleared, aborting any transaction in progress with no pulse emitted.
  - `read_audio_in`=0, `write_audio_out`=0.
  - Both output channels = 0.
  - `drop_count`=0.
  - Phase, accumulators, and wait counter = 0.

## Timing
- All outputs are registered. No combinational path from input to output.
- Available seen at edge t → `read_audio_in` high in cycle t+1 only.
- With `audio_out_allowed` already high: `write_audio_out` high in cycle t+3. Minimum latency is 3 cycles, and throughput is at most one sample per 4 cycles.
- `read_audio_in` and `write_audio_out` are never high in the same cycle. Neither is ever high for 2 consecutive cycles.
- `audio_in_available` is ignored outside WAIT_IN. `audio_out_allowed` is ignored outside WAIT_OUT.
- Output data changes only on the edge that ends CAPTURE and is valid throughout EMIT.
- Timeout: with `audio_out_allowed` held low, the block re-enters WAIT_IN exactly OUT_TIMEOUT cycles after entering WAIT_OUT.

## Test plan
1. **Reset values.** Hold `reset`=0 for 3 cycles with `audio_in_available`=`audio_out_allowed`=1 → all outputs 0 and no pulses. Release → first `read_audio_in` 1 cycle later and `write_audio_out` 3 cycles later.
2. **MODE 0 decimation.** MODE=0, FACTOR_LOG2=2, allowed=1, left inputs 1..8 → 8 writes with left_out 1,1,1,1,5,5,5,5. Right channel is checked the same way with negated values.
3. **MODE 1 block average.** MODE=1, FACTOR_LOG2=2, inputs 4,8,−4,0 then 1,1,1,2 → writes 0,0,0,2 then 2,2,2,1. Also inputs −1,0,0,0 → −1 (arithmetic floor).
4. **Backpressure.** `audio_out_allowed`=0 for 10 cycles with OUT_TIMEOUT=1024 → no `write_audio_out`, no second `read_audio_in`. Raise allowed → `write_audio_out` the next cycle with the correct sample.
5. **Timeout and saturation.** OUT_TIMEOUT=4 and allowed stuck low → each sample is read, no write, `drop_count` increments by 1 per sample. Preload near saturation → the count stays at 16'hFFFF.
6. **Bypass and mid-operation reset.** Toggle `bypass` mid-block → raw samples while high, phase restarts at 0 after 1→0. Assert `reset` in WAIT_OUT → no EMIT pulse and `drop_count` unchanged at 0.
